// File: rtl/bp_cmd_pkg.sv
// -----------------------------------------------------------------------------
// bp_cmd_pkg
// Shared definitions for the single-pin command sequencer:
//   - op_e      : two-bit frame opcode
//   - state_e   : frame parser states
//   - payload lengths per opcode, payload shift-register and counter widths
//   - payload_len() : payload bit count for a given opcode
// -----------------------------------------------------------------------------
package bp_cmd_pkg;

    typedef enum logic [1:0] {
        OP_IC_WR  = 2'b00,
        OP_BP_UPD = 2'b01,
        OP_DUMP   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPC     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_STOP    = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_DUMP    = 3'd5
    } state_e;

    // Payload lengths in bits. IC_WR is address (8) followed by data (32).
    localparam int unsigned IC_WR_LEN  = 40;
    localparam int unsigned BP_UPD_LEN = 99;
    localparam int unsigned DUMP_LEN   = 0;

    // The payload register is sized for the longest frame.
    localparam int unsigned PAYLOAD_W  = BP_UPD_LEN;
    localparam int unsigned CNT_W      = 7;

    function automatic int unsigned payload_len(input op_e op);
        case (op)
            OP_IC_WR:  return IC_WR_LEN;
            OP_BP_UPD: return BP_UPD_LEN;
            default:   return DUMP_LEN;
        endcase
    endfunction

endpackage

// File: rtl/bp_readout_shifter.sv
// -----------------------------------------------------------------------------
// bp_readout_shifter
// Parallel-load, MSB-first serialiser. The word loaded on load_i appears on
// ser_o starting the cycle after the load edge, one bit per clock, for WIDTH
// cycles. done_o is high while the final (LSB) bit is on ser_o. ser_o is 0
// whenever no word is being shifted out.
// Ports:
//   clk     : clock
//   rst_ni  : synchronous active-low reset
//   load_i  : capture data_i and start shifting
//   data_i  : word to shift out
//   ser_o   : serial output, MSB first
//   done_o  : last bit is being presented
// -----------------------------------------------------------------------------
module bp_readout_shifter #(
    parameter int unsigned WIDTH = 89
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ser_o,
    output logic             done_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            sr_q     <= data_i;
            cnt_q    <= CW'(WIDTH - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                // Clearing the register is what returns ser_o to 0.
                active_q <= 1'b0;
                sr_q     <= '0;
            end else begin
                sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign ser_o  = sr_q[WIDTH-1];
    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/bp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// bp_cmd_sequencer
// Single-pin framed command decoder for the branch-predictor test top.
// Frame: start(1) opcode(2) payload(N, MSB first) stop(0).
//   00 IC_WR  : N=40  {address, data}          -> one-cycle ic_wren
//   01 BP_UPD : N=99  {PC, target, meta, dir, miss, ras} -> one-cycle bp_update
//   10 DUMP   : N=0   serialises {fetch_p_target, fetch_meta, fetch_p_dir, ic_q}
//                     on ser_out, MSB first, 89 bits
//   11        : dropped after the opcode
// Ports:
//   clk, reset (sync active-low), ser_in (command stream), ser_out (readout)
//   busy, frame_err (bad stop bit pulse)
//   ic_wren / ic_wraddress / ic_data            : cache write port
//   bp_update / bp_PC / bp_target / bp_meta /
//   bp_dir / bp_miss / bp_recover_ras           : predictor update port
//   fetch_p_target / fetch_meta / fetch_p_dir / ic_q : readout snapshot inputs
// Timing: with the start bit sampled at edge 0, frame_err rises at edge N+3
// and the command strobe at edge N+4, together with its fields.
// -----------------------------------------------------------------------------
module bp_cmd_sequencer
    import bp_cmd_pkg::*;
#(
    parameter int unsigned IC_AW  = 8,
    parameter int unsigned IC_DW  = 32,
    parameter int unsigned META_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_in,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_err,
    output logic              ic_wren,
    output logic [IC_AW-1:0]  ic_wraddress,
    output logic [IC_DW-1:0]  ic_data,
    output logic              bp_update,
    output logic [31:0]       bp_PC,
    output logic [31:0]       bp_target,
    output logic [31:0]       bp_meta,
    output logic              bp_dir,
    output logic              bp_miss,
    output logic              bp_recover_ras,
    input  logic [31:0]       fetch_p_target,
    input  logic [META_W-1:0] fetch_meta,
    input  logic              fetch_p_dir,
    input  logic [IC_DW-1:0]  ic_q
);

    localparam int unsigned RD_W = 32 + META_W + 1 + IC_DW;

    // BP_UPD payload layout, first-received field in the MSBs.
    localparam int unsigned PC_HI   = PAYLOAD_W - 1;
    localparam int unsigned TGT_HI  = PC_HI - 32;
    localparam int unsigned META_HI = TGT_HI - 32;

    state_e               state_q;
    op_e                  opcode_q;
    logic                 opc_hi_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 rearm_q;

    logic                 busy_q;
    logic                 frame_err_q;
    logic                 ic_wren_q;
    logic [IC_AW-1:0]     ic_wraddress_q;
    logic [IC_DW-1:0]     ic_data_q;
    logic                 bp_update_q;
    logic [31:0]          bp_pc_q;
    logic [31:0]          bp_target_q;
    logic [31:0]          bp_meta_q;
    logic                 bp_dir_q;
    logic                 bp_miss_q;
    logic                 bp_ras_q;

    op_e                  opc_next;
    logic                 dump_load;
    logic                 dump_done;
    logic [RD_W-1:0]      dump_word;

    // Opcode formed from the bit captured in the first OPC cycle and the
    // bit on the line now.
    assign opc_next  = op_e'({opc_hi_q, ser_in});

    // The snapshot is taken on the same edge that enters DUMP.
    assign dump_load = (state_q == ST_STOP) && (opcode_q == OP_DUMP) && !ser_in;
    assign dump_word = {fetch_p_target, fetch_meta, fetch_p_dir, ic_q};

    bp_readout_shifter #(
        .WIDTH (RD_W)
    ) u_readout (
        .clk    (clk),
        .rst_ni (reset),
        .load_i (dump_load),
        .data_i (dump_word),
        .ser_o  (ser_out),
        .done_o (dump_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            opcode_q       <= OP_IC_WR;
            opc_hi_q       <= 1'b0;
            cnt_q          <= '0;
            payload_q      <= '0;
            rearm_q        <= 1'b0;
            busy_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            ic_wren_q      <= 1'b0;
            ic_wraddress_q <= '0;
            ic_data_q      <= '0;
            bp_update_q    <= 1'b0;
            bp_pc_q        <= '0;
            bp_target_q    <= '0;
            bp_meta_q      <= '0;
            bp_dir_q       <= 1'b0;
            bp_miss_q      <= 1'b0;
            bp_ras_q       <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            frame_err_q <= 1'b0;
            ic_wren_q   <= 1'b0;
            bp_update_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    // After ISSUE/DUMP the line has to be seen low once
                    // before a new start bit counts.
                    if (!ser_in) begin
                        rearm_q <= 1'b0;
                    end else if (!rearm_q) begin
                        state_q <= ST_OPC;
                        busy_q  <= 1'b1;
                    end
                end

                ST_OPC: begin
                    if (cnt_q == '0) begin
                        opc_hi_q <= ser_in;
                        cnt_q    <= cnt_q + 1'b1;
                    end else begin
                        cnt_q    <= '0;
                        opcode_q <= opc_next;
                        if (opc_next == OP_RSVD) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else if (payload_len(opc_next) != DUMP_LEN) begin
                            state_q <= ST_PAYLOAD;
                        end else begin
                            state_q <= ST_STOP;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    payload_q <= {payload_q[PAYLOAD_W-2:0], ser_in};
                    if (cnt_q == CNT_W'(payload_len(opcode_q) - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (ser_in) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end else if (opcode_q == OP_DUMP) begin
                        state_q <= ST_DUMP;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (opcode_q == OP_IC_WR) begin
                        ic_wraddress_q <= payload_q[IC_AW+IC_DW-1 -: IC_AW];
                        ic_data_q      <= payload_q[IC_DW-1:0];
                        ic_wren_q      <= 1'b1;
                    end else begin
                        bp_pc_q     <= payload_q[PC_HI -: 32];
                        bp_target_q <= payload_q[TGT_HI -: 32];
                        bp_meta_q   <= payload_q[META_HI -: 32];
                        bp_dir_q    <= payload_q[2];
                        bp_miss_q   <= payload_q[1];
                        bp_ras_q    <= payload_q[0];
                        bp_update_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    rearm_q <= 1'b1;
                end

                ST_DUMP: begin
                    if (dump_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        rearm_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign frame_err      = frame_err_q;
    assign ic_wren        = ic_wren_q;
    assign ic_wraddress   = ic_wraddress_q;
    assign ic_data        = ic_data_q;
    assign bp_update      = bp_update_q;
    assign bp_PC          = bp_pc_q;
    assign bp_target      = bp_target_q;
    assign bp_meta        = bp_meta_q;
    assign bp_dir         = bp_dir_q;
    assign bp_miss        = bp_miss_q;
    assign bp_recover_ras = bp_ras_q;

endmodule

// File: tb/tb_bp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bp_cmd_sequencer
// Frame-level stimulus with a scoreboard. Each command pushes its expected
// outcome (event kind, edge index, full field set, readout bits) into exp_q;
// an independent negedge monitor pops and compares whenever the DUT shows a
// strobe, frame error, readout stream or reset state.
// -----------------------------------------------------------------------------
module tb_bp_cmd_sequencer;

    localparam int IC_AW  = 8;
    localparam int IC_DW  = 32;
    localparam int META_W = 24;
    localparam int RD_W   = 32 + META_W + 1 + IC_DW;

    localparam int K_IC   = 0;
    localparam int K_BP   = 1;
    localparam int K_ERR  = 2;
    localparam int K_DUMP = 3;
    localparam int K_RST  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ser_in = 1'b0;
    logic              ser_out;
    logic              busy;
    logic              frame_err;
    logic              ic_wren;
    logic [IC_AW-1:0]  ic_wraddress;
    logic [IC_DW-1:0]  ic_data;
    logic              bp_update;
    logic [31:0]       bp_PC;
    logic [31:0]       bp_target;
    logic [31:0]       bp_meta;
    logic              bp_dir;
    logic              bp_miss;
    logic              bp_recover_ras;
    logic [31:0]       fetch_p_target = '0;
    logic [META_W-1:0] fetch_meta = '0;
    logic              fetch_p_dir = 1'b0;
    logic [IC_DW-1:0]  ic_q = '0;

    bp_cmd_sequencer #(
        .IC_AW  (IC_AW),
        .IC_DW  (IC_DW),
        .META_W (META_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ser_in         (ser_in),
        .ser_out        (ser_out),
        .busy           (busy),
        .frame_err      (frame_err),
        .ic_wren        (ic_wren),
        .ic_wraddress   (ic_wraddress),
        .ic_data        (ic_data),
        .bp_update      (bp_update),
        .bp_PC          (bp_PC),
        .bp_target      (bp_target),
        .bp_meta        (bp_meta),
        .bp_dir         (bp_dir),
        .bp_miss        (bp_miss),
        .bp_recover_ras (bp_recover_ras),
        .fetch_p_target (fetch_p_target),
        .fetch_meta     (fetch_meta),
        .fetch_p_dir    (fetch_p_dir),
        .ic_q           (ic_q)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct packed {
        logic [7:0]  ic_addr;
        logic [31:0] ic_data;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] meta;
        logic        dir;
        logic        miss;
        logic        ras;
    } fields_t;

    typedef struct {
        int              kind;
        int              at;
        logic [RD_W-1:0] dbits;
        fields_t         f;
    } exp_t;

    exp_t    exp_q[$];
    fields_t model = '0;
    int      tests = 0;
    int      fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_fields(input fields_t f);
        check("ic_wraddress",   128'(ic_wraddress),   128'(f.ic_addr));
        check("ic_data",        128'(ic_data),        128'(f.ic_data));
        check("bp_PC",          128'(bp_PC),          128'(f.pc));
        check("bp_target",      128'(bp_target),      128'(f.tgt));
        check("bp_meta",        128'(bp_meta),        128'(f.meta));
        check("bp_dir",         128'(bp_dir),         128'(f.dir));
        check("bp_miss",        128'(bp_miss),        128'(f.miss));
        check("bp_recover_ras", 128'(bp_recover_ras), 128'(f.ras));
    endtask

    // ------------------------------------------------------------------ monitor
    exp_t mon_e;
    int   mon_kind;
    bit   dump_win;

    always @(negedge clk) begin
        dump_win = (exp_q.size() > 0) && (exp_q[0].kind == K_DUMP) && (edge_cnt >= exp_q[0].at);
        check("strobe_exclusive", 128'(ic_wren & bp_update), 128'(0));

        if (ic_wren || bp_update || frame_err) begin
            mon_kind = ic_wren ? K_IC : (bp_update ? K_BP : K_ERR);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 128'({ic_wren, bp_update, frame_err}), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] edge %0d event kind %0d (expected kind %0d at %0d)",
                         edge_cnt, mon_kind, mon_e.kind, mon_e.at);
                check("event_kind", 128'(mon_kind), 128'(mon_e.kind));
                check("event_edge", 128'(edge_cnt), 128'(mon_e.at));
                check("busy_at_event", 128'(busy), 128'(0));
                check_fields(mon_e.f);
            end
        end else if (dump_win) begin
            mon_e = exp_q[0];
            if (edge_cnt < mon_e.at + RD_W) begin
                check("dump_bit", 128'(ser_out), 128'(mon_e.dbits[RD_W-1-(edge_cnt-mon_e.at)]));
                check("dump_busy", 128'(busy), 128'(1));
            end else begin
                $display("[TB] edge %0d dump of %0h complete", edge_cnt, mon_e.dbits);
                check("dump_end_ser_out", 128'(ser_out), 128'(0));
                check("dump_end_busy", 128'(busy), 128'(0));
                check_fields(mon_e.f);
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0].kind == K_RST && edge_cnt >= exp_q[0].at) begin
            mon_e = exp_q.pop_front();
            $display("[TB] edge %0d reset state check", edge_cnt);
            check("rst_edge", 128'(edge_cnt), 128'(mon_e.at));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_ser_out", 128'(ser_out), 128'(0));
            check_fields(mon_e.f);
        end else if (exp_q.size() > 0 && exp_q[0].kind <= K_ERR && edge_cnt > exp_q[0].at) begin
            check("missing_event", 128'(edge_cnt), 128'(exp_q[0].at));
            void'(exp_q.pop_front());
        end

        if (!dump_win) check("ser_out_idle", 128'(ser_out), 128'(0));
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send_bit(input logic b);
        ser_in = b;
        @(posedge clk);
        #1;
    endtask

    // Issue one framed command; expected outcome is derived from the frame
    // rules and pushed before the first bit goes out.
    task automatic do_cmd(input logic [1:0] op, input fields_t nf, input logic stop);
        int         e0;
        int         n;
        logic [98:0] pl;
        exp_t       e;
        e0 = edge_cnt + 1;
        n  = (op == 2'b00) ? 40 : ((op == 2'b01) ? 99 : 0);
        pl = '0;
        if (op == 2'b00) pl[39:0] = {nf.ic_addr, nf.ic_data};
        else if (op == 2'b01) pl = {nf.pc, nf.tgt, nf.meta, nf.dir, nf.miss, nf.ras};

        if (op != 2'b11) begin
            e.dbits = '0;
            if (stop) begin
                e.kind = K_ERR;
                e.at   = e0 + n + 3;
            end else if (op == 2'b10) begin
                e.kind  = K_DUMP;
                e.at    = e0 + 3;
                e.dbits = {fetch_p_target, fetch_meta, fetch_p_dir, ic_q};
            end else begin
                if (op == 2'b00) begin
                    model.ic_addr = nf.ic_addr;
                    model.ic_data = nf.ic_data;
                    e.kind = K_IC;
                end else begin
                    model.pc   = nf.pc;
                    model.tgt  = nf.tgt;
                    model.meta = nf.meta;
                    model.dir  = nf.dir;
                    model.miss = nf.miss;
                    model.ras  = nf.ras;
                    e.kind = K_BP;
                end
                e.at = e0 + n + 4;
            end
            e.f = model;
            exp_q.push_back(e);
        end
        $display("[TB] edge %0d send op %b stop %b", e0, op, stop);

        send_bit(1'b1);
        send_bit(op[1]);
        send_bit(op[0]);
        for (int i = n - 1; i >= 0; i--) send_bit(pl[i]);
        if (op != 2'b11) send_bit(stop);
        // Line activity during readout must be ignored.
        if (op == 2'b10 && !stop)
            for (int i = 0; i < RD_W; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (2 + $urandom_range(0, 2)) send_bit(1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        f.ic_addr = 8'($urandom);
        f.ic_data = $urandom;
        f.pc      = $urandom;
        f.tgt     = $urandom;
        f.meta    = $urandom;
        f.dir     = 1'($urandom_range(0, 1));
        f.miss    = 1'($urandom_range(0, 1));
        f.ras     = 1'($urandom_range(0, 1));
        return f;
    endfunction

    exp_t    rst_e;
    fields_t nf;
    logic [1:0] rop;

    initial begin
        // Reset state at the first edge.
        rst_e.kind = K_RST;
        rst_e.at   = edge_cnt + 1;
        rst_e.dbits = '0;
        rst_e.f    = model;
        exp_q.push_back(rst_e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) send_bit(1'b0);

        // Directed: IC_WR
        nf = rand_fields();
        nf.ic_addr = 8'h3C;
        nf.ic_data = 32'hDEADBEEF;
        do_cmd(2'b00, nf, 1'b0);

        // Directed: BP_UPD
        nf = rand_fields();
        nf.pc = 32'h0000_0040; nf.tgt = 32'h0000_0100; nf.meta = 32'h00AB_CDEF;
        nf.dir = 1'b1; nf.miss = 1'b1; nf.ras = 1'b0;
        do_cmd(2'b01, nf, 1'b0);

        // Directed: IC_WR with bad stop bit, fields must hold
        do_cmd(2'b00, rand_fields(), 1'b1);

        // Directed: DUMP
        fetch_p_target = 32'h12345678;
        fetch_meta     = 24'hA5A5A5;
        fetch_p_dir    = 1'b1;
        ic_q           = 32'hCAFEF00D;
        do_cmd(2'b10, rand_fields(), 1'b0);

        // Directed: reserved opcode, then a normal IC_WR
        do_cmd(2'b11, rand_fields(), 1'b0);
        do_cmd(2'b00, rand_fields(), 1'b0);
        wait_drain();

        // Randomised command mix
        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'b10) begin
                fetch_p_target = $urandom;
                fetch_meta     = 24'($urandom);
                fetch_p_dir    = 1'($urandom_range(0, 1));
                ic_q           = $urandom;
            end
            do_cmd(rop, rand_fields(), $urandom_range(0, 5) == 0);
        end
        wait_drain();

        // Reset in the middle of a BP_UPD payload (payload bit 20)
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        reset  = 1'b0;
        ser_in = 1'b1;
        model  = '0;
        rst_e.kind = K_RST;
        rst_e.at   = edge_cnt + 1;
        rst_e.f    = model;
        exp_q.push_back(rst_e);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) send_bit(1'b0);

        // Complete frame after reset
        do_cmd(2'b01, rand_fields(), 1'b0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
